// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline constants and types for the decode-side hazard controller.
// No logic here: register address width, x0, and the jb squash/pass encoding.
package hazard_ctrl_pkg;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_X0    = 5'd0;
  localparam logic      JB_SQUASH = 1'b0;
  localparam logic      JB_PASS   = 1'b1;

  // Destination of the instruction currently sitting in E.
  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
    logic      load;
  } ex_shadow_t;

  function automatic logic src_hit(logic use_src, reg_addr_t src, reg_addr_t rd);
    return use_src && (src == rd);
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage operand info in, stall/squash/freeze controls and perf counters out.
// master = pipeline side, slave = hazard controller.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  import hazard_ctrl_pkg::*;

  logic             d_valid;
  reg_addr_t        d_rs1;
  reg_addr_t        d_rs2;
  logic             d_use_rs1;
  logic             d_use_rs2;
  reg_addr_t        d_rd;
  logic             d_reg_write;
  logic             d_is_load;
  logic             e_jb_taken;
  logic             mem_busy;
  logic             stall;
  logic             jb;
  logic             flush_d;
  logic             freeze;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2, d_rd, d_reg_write, d_is_load,
    output e_jb_taken, mem_busy,
    input  stall, jb, flush_d, freeze, stall_cnt, flush_cnt
  );

  modport slave (
    input  d_valid, d_rs1, d_rs2, d_use_rs1, d_use_rs2, d_rd, d_reg_write, d_is_load,
    input  e_jb_taken, mem_busy,
    output stall, jb, flush_d, freeze, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// Latency: count visible the cycle after en; en is the only hold control.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, taken-branch flush window and global freeze for the D/E registers.
// Latency: controls are combinational from D/E state; mem_busy freezes every register here too.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);
  localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYC - 1);

  ex_shadow_t ex_q;
  logic [2:0] fl_cnt;
  logic       load_use;
  logic       flushing;
  logic       frozen;
  logic       stall;
  logic       jb;
  logic       flush_d;
  logic       freeze;
  logic       stall_en;
  logic       flush_en;

  assign frozen   = hz.mem_busy;
  assign flushing = hz.e_jb_taken | (fl_cnt != 3'd0);
  assign load_use = hz.d_valid & ex_q.valid & ex_q.load & (ex_q.rd != REG_X0) &
                    (src_hit(hz.d_use_rs1, hz.d_rs1, ex_q.rd) |
                     src_hit(hz.d_use_rs2, hz.d_rs2, ex_q.rd));

  // Freeze wins over flush: E holds and will re-present a coincident taken branch.
  always_comb begin
    stall   = 1'b0;
    jb      = JB_PASS;
    flush_d = 1'b0;
    freeze  = 1'b0;
    if (!rst) begin
      jb      = JB_SQUASH;
      flush_d = 1'b1;
    end else if (frozen) begin
      freeze  = 1'b1;
    end else if (flushing) begin
      jb      = JB_SQUASH;
      flush_d = 1'b1;
    end else if (load_use) begin
      stall   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fl_cnt <= 3'd0;
      ex_q   <= '0;
    end else if (!frozen) begin
      if (hz.e_jb_taken) begin
        fl_cnt <= FL_RELOAD;
      end else if (fl_cnt != 3'd0) begin
        fl_cnt <= fl_cnt - 3'd1;
      end
      if (stall || (jb == JB_SQUASH)) begin
        ex_q.valid <= 1'b0;
      end else begin
        ex_q.valid <= hz.d_valid;
        ex_q.rd    <= hz.d_rd;
        ex_q.load  <= hz.d_is_load & hz.d_reg_write;
      end
    end
  end

  assign stall_en = stall & ~frozen;
  assign flush_en = hz.e_jb_taken & ~frozen;

  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .en(stall_en), .q(hz.stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .en(flush_en), .q(hz.flush_cnt));

  assign hz.stall   = stall;
  assign hz.jb      = jb;
  assign hz.flush_d = flush_d;
  assign hz.freeze  = freeze;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Two hazard_ctrl instances (FLUSH_CYC=2/CNT_W=4 and FLUSH_CYC=4/CNT_W=32) on shared stimulus,
// checked every cycle against a cycle-index model plus directed literal expectations.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       d_valid, d_use_rs1, d_use_rs2, d_reg_write, d_is_load, e_jb_taken, mem_busy;
  logic [4:0] d_rs1, d_rs2, d_rd;

  int n_chk = 0;
  int n_err = 0;
  bit run   = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(4))  if_a ();
  hazard_ctrl_if #(.CNT_W(32)) if_b ();

  assign if_a.d_valid = d_valid;         assign if_b.d_valid = d_valid;
  assign if_a.d_rs1 = d_rs1;             assign if_b.d_rs1 = d_rs1;
  assign if_a.d_rs2 = d_rs2;             assign if_b.d_rs2 = d_rs2;
  assign if_a.d_use_rs1 = d_use_rs1;     assign if_b.d_use_rs1 = d_use_rs1;
  assign if_a.d_use_rs2 = d_use_rs2;     assign if_b.d_use_rs2 = d_use_rs2;
  assign if_a.d_rd = d_rd;               assign if_b.d_rd = d_rd;
  assign if_a.d_reg_write = d_reg_write; assign if_b.d_reg_write = d_reg_write;
  assign if_a.d_is_load = d_is_load;     assign if_b.d_is_load = d_is_load;
  assign if_a.e_jb_taken = e_jb_taken;   assign if_b.e_jb_taken = e_jb_taken;
  assign if_a.mem_busy = mem_busy;       assign if_b.mem_busy = mem_busy;

  hazard_ctrl #(.FLUSH_CYC(2), .CNT_W(4))  dut_a (.clk(clk), .rst(rst), .hz(if_a.slave));
  hazard_ctrl #(.FLUSH_CYC(4), .CNT_W(32)) dut_b (.clk(clk), .rst(rst), .hz(if_b.slave));

  // Model: unfrozen-cycle index, the index at which the squash window ends,
  // and what instruction was accepted into E.
  int         fcyc [2] = '{2, 4};
  int         wbits[2] = '{4, 32};
  longint     act_cyc[2], sq_end[2], m_scnt[2], m_fcnt[2];
  bit         e_v[2], e_ld[2];
  logic [4:0] e_rd[2];

  function automatic void m_out(int i, output bit s, output bit j, output bit fd, output bit fz);
    bit fl, lu;
    s = 0; j = 1; fd = 0; fz = 0;
    if (!rst) begin
      j = 0; fd = 1;
    end else if (mem_busy) begin
      fz = 1;
    end else begin
      fl = e_jb_taken || (act_cyc[i] < sq_end[i]);
      lu = d_valid && e_v[i] && e_ld[i] && (e_rd[i] != 0) &&
           ((d_use_rs1 && d_rs1 == e_rd[i]) || (d_use_rs2 && d_rs2 == e_rd[i]));
      if (fl) begin j = 0; fd = 1; end
      else if (lu) s = 1;
    end
  endfunction

  function automatic logic [63:0] sat(int i, longint c);
    longint mx = (longint'(1) << wbits[i]) - 1;
    return (c > mx) ? mx : c;
  endfunction

  always @(posedge clk) begin
    bit s, j, fd, fz;
    for (int i = 0; i < 2; i++) begin
      m_out(i, s, j, fd, fz);
      if (!rst) begin
        act_cyc[i] = 0; sq_end[i] = 0; m_scnt[i] = 0; m_fcnt[i] = 0; e_v[i] = 0;
      end else if (!mem_busy) begin
        if (e_jb_taken) sq_end[i] = act_cyc[i] + fcyc[i];
        act_cyc[i]++;
        if (s || !j) e_v[i] = 0;
        else begin
          e_v[i] = d_valid; e_rd[i] = d_rd; e_ld[i] = d_is_load && d_reg_write;
        end
        if (s) m_scnt[i]++;
        if (e_jb_taken) m_fcnt[i]++;
      end
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit s, j, fd, fz;
    if (run) begin
      m_out(0, s, j, fd, fz);
      chk("a_stall", if_a.stall, s);     chk("a_jb", if_a.jb, j);
      chk("a_flush_d", if_a.flush_d, fd); chk("a_freeze", if_a.freeze, fz);
      chk("a_stall_cnt", if_a.stall_cnt, rst ? sat(0, m_scnt[0]) : 0);
      chk("a_flush_cnt", if_a.flush_cnt, rst ? sat(0, m_fcnt[0]) : 0);
      m_out(1, s, j, fd, fz);
      chk("b_stall", if_b.stall, s);     chk("b_jb", if_b.jb, j);
      chk("b_flush_d", if_b.flush_d, fd); chk("b_freeze", if_b.freeze, fz);
      chk("b_stall_cnt", if_b.stall_cnt, rst ? sat(1, m_scnt[1]) : 0);
      chk("b_flush_cnt", if_b.flush_cnt, rst ? sat(1, m_fcnt[1]) : 0);
    end
  end

  task automatic set_d(bit v, logic [4:0] rs1, logic [4:0] rs2, bit u1, bit u2,
                       logic [4:0] rd, bit rw, bit ld);
    d_valid = v; d_rs1 = rs1; d_rs2 = rs2; d_use_rs1 = u1; d_use_rs2 = u2;
    d_rd = rd; d_reg_write = rw; d_is_load = ld;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; e_jb_taken = 0; mem_busy = 0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    run = 1'b1;
    @(negedge clk);
    chk("rst_stall", if_a.stall, 0);   chk("rst_jb", if_a.jb, 0);
    chk("rst_flush_d", if_a.flush_d, 1); chk("rst_freeze", if_a.freeze, 0);
    nxt(); nxt(); rst = 1'b1;
    nxt();

    // Load-use: lw x5 then add reading x5
    set_d(1, 0, 0, 0, 0, 5, 1, 1); nxt();
    set_d(1, 5, 0, 1, 0, 1, 1, 0);
    @(negedge clk); chk("lu_stall", if_a.stall, 1); chk("lu_jb", if_a.jb, 1);
    nxt();
    @(negedge clk); chk("lu_stall_after", if_a.stall, 0); chk("lu_cnt", if_a.stall_cnt, 1);
    nxt();

    // Load into x0 never stalls
    set_d(1, 0, 0, 0, 0, 0, 1, 1); nxt();
    set_d(1, 0, 0, 1, 1, 2, 1, 0);
    @(negedge clk); chk("x0_stall", if_a.stall, 0); nxt();
    @(negedge clk); chk("x0_cnt", if_a.stall_cnt, 1);

    // Taken branch coinciding with a load-use
    set_d(1, 0, 0, 0, 0, 7, 1, 1); nxt();
    set_d(1, 0, 7, 0, 1, 1, 1, 0); e_jb_taken = 1;
    @(negedge clk); chk("br_t_jb", if_a.jb, 0); chk("br_t_fd", if_a.flush_d, 1);
    chk("br_t_stall", if_a.stall, 0);
    nxt(); e_jb_taken = 0;
    @(negedge clk); chk("br_t1_jb", if_a.jb, 0); chk("br_t1_fd", if_a.flush_d, 1);
    nxt();
    @(negedge clk); chk("br_t2_jb", if_a.jb, 1); chk("br_t2_stall", if_a.stall, 0);
    chk("br_t2_b_jb", if_b.jb, 0); chk("br_fcnt", if_a.flush_cnt, 1);
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) nxt();

    // Freeze over a pending load-use
    set_d(1, 0, 0, 0, 0, 9, 1, 1); nxt();
    set_d(1, 9, 0, 1, 0, 1, 1, 0); mem_busy = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("frz_freeze", if_a.freeze, 1); chk("frz_stall", if_a.stall, 0);
      chk("frz_jb", if_a.jb, 1); chk("frz_cnt", if_a.stall_cnt, 1);
      nxt();
    end
    mem_busy = 0;
    @(negedge clk); chk("frz_rel_stall", if_a.stall, 1); nxt();
    @(negedge clk); chk("frz_rel_once", if_a.stall, 0); chk("frz_rel_cnt", if_a.stall_cnt, 2);

    // Twenty more load-use stalls: 4-bit counter pins at 15
    for (int k = 0; k < 20; k++) begin
      set_d(1, 0, 0, 0, 0, 3, 1, 1); nxt();
      set_d(1, 3, 0, 1, 0, 4, 1, 0); nxt(); nxt();
    end
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("sat_a", if_a.stall_cnt, 15); chk("sat_b", if_b.stall_cnt, 22);
    nxt();

    // Reset asserted between edges inside a FLUSH_CYC=4 window
    e_jb_taken = 1; nxt(); e_jb_taken = 0;
    #2 rst = 1'b0; #1;
    chk("mr_stall", if_b.stall, 0); chk("mr_jb", if_b.jb, 0); chk("mr_fd", if_b.flush_d, 1);
    chk("mr_scnt", if_b.stall_cnt, 0); chk("mr_fcnt", if_b.flush_cnt, 0);
    nxt(); rst = 1'b1;
    @(negedge clk); chk("mr_after_jb", if_b.jb, 1);
    nxt();

    // Randomised traffic, small register range to make hazards frequent
    for (int k = 0; k < 800; k++) begin
      rst        = ($urandom_range(0, 149) != 0);
      mem_busy   = ($urandom_range(0, 7) == 0);
      e_jb_taken = ($urandom_range(0, 9) == 0);
      set_d($urandom_range(0, 4) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      nxt();
    end
    rst = 1'b1;
    @(negedge clk);
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Control source for the pipeline-register stall/squash interface. It produces the `stall` and `jb` inputs consumed by the D->E register, plus the F->D squash and global freeze.
- Sits beside the decode stage.
- Tracks the destination of the instruction currently in E, detects load-use hazards, and runs a multi-cycle flush window on taken branches/jumps.
- Keeps saturating performance counters of stall and flush events.

Parameters:
- FLUSH_CYC, 1, cycles `jb` is held low after a taken branch/jump (1..7)
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  clock; all state on posedge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- d_valid  in  1  D stage holds a real instruction
- d_rs1  in  5  D source register 1
- d_rs2  in  5  D source register 2
- d_use_rs1  in  1  D instruction reads rs1
- d_use_rs2  in  1  D instruction reads rs2
- d_rd  in  5  D destination register
- d_reg_write  in  1  D instruction writes rd
- d_is_load  in  1  D instruction is a load
- e_jb_taken  in  1  E resolved a taken branch or jump this cycle
- mem_busy  in  1  memory not ready; whole pipe must hold
- stall  out  1  1 = hold PC and F->D, bubble into E
- jb  out  1  0 = squash D->E (bubble), 1 = pass
- flush_d  out  1  1 = squash F->D
- freeze  out  1  1 = every pipeline register holds
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of accepted taken-branch events

Behaviour:
- Internal state:
  - E shadow: ex_valid, ex_rd[4:0], ex_load.
  - fl_cnt[2:0]: remaining flush cycles.
  - stall_cnt and flush_cnt.
- Reset (rst=0, asynchronous), clearing all state:
  - ex_valid=0, fl_cnt=0, counters=0.
  - While rst=0, outputs are forced to stall=0, jb=0, flush_d=1, freeze=0.
- freeze = mem_busy (combinational).
- load_use asserts when all of the following hold:
  - d_valid & ex_valid & ex_load & (ex_rd != 0)
  - (d_use_rs1 & d_rs1==ex_rd) | (d_use_rs2 & d_rs2==ex_rd)
- flushing = e_jb_taken | (fl_cnt != 0).
- Priority, combinational, same cycle:
  - freeze=1: stall=0, jb=1, flush_d=0. All state holds, including fl_cnt and counters. A coincident e_jb_taken is ignored because E holds and re-presents it.
  - else flushing: jb=0, flush_d=1, stall=0. Load-use is suppressed because the D instruction is wrong-path.
  - else load_use: stall=1, jb=1, flush_d=0.
  - else: stall=0, jb=1, flush_d=0.
- fl_cnt update, only when not frozen:
  - On e_jb_taken, fl_cnt <= FLUSH_CYC-1. A new taken event during an active window restarts it.
  - Otherwise, if fl_cnt != 0, fl_cnt decrements.
  - Net effect: the squash lasts exactly FLUSH_CYC cycles starting in the e_jb_taken cycle.
- E shadow update, only when not frozen:
  - If stall | ~jb: ex_valid <= 0.
  - Else: ex_valid <= d_valid, ex_rd <= d_rd, ex_load <= d_is_load & d_reg_write.
  - A load-use stall therefore lasts exactly 1 cycle.
- Counters, when not frozen:
  - stall_cnt += 1 on each cycle with stall=1.
  - flush_cnt += 1 on each cycle with e_jb_taken=1.
  - Both saturate at all-ones; they never wrap.
- No forwarding decisions here: M/W hazards are assumed resolved by the forwarding unit. Only the E-stage load causes a stall.

Decomposition:
- Shared pipeline package:
  - REG_ADDR_W=5, REG_X0=5'd0.
  - Stall/flush encoding constants: JB_SQUASH=1'b0, JB_PASS=1'b1.
- One natural sub-module: sat_counter (param W; inputs clk, rst, en; output q). It is instantiated twice.

Test Plan:
1. Load-use:
   - Stimulus: cycle 0 D = lw rd=5 (d_is_load=1, d_reg_write=1); cycle 1 D = add rs1=5, d_use_rs1=1.
   - Required: cycle 1 stall=1, jb=1. Cycle 2 (same D) stall=0. stall_cnt=1.
2. x0 load:
   - Stimulus: lw rd=0 followed by a reader of x0.
   - Required: stall stays 0 throughout; stall_cnt=0.
3. Taken branch, FLUSH_CYC=2:
   - Stimulus: e_jb_taken pulse at cycle t, with a load-use present at t.
   - Required: jb=0 and flush_d=1 at t and t+1; stall=0. jb=1 at t+2. flush_cnt=1. ex_valid=0 after t+1.
4. Freeze:
   - Stimulus: mem_busy=1 for cycles 5..7 while a load-use condition holds.
   - Required: freeze=1, stall=0, jb=1 for 3 cycles; stall_cnt unchanged. Cycle 8 stall=1 exactly once.
5. Counter saturation:
   - Stimulus: CNT_W=4 and 20 separate load-use stalls.
   - Required: stall_cnt=4'hF, no wrap.
6. Reset mid-flush:
   - Stimulus: FLUSH_CYC=4, e_jb_taken, then rst=0 asserted between clock edges 1 cycle later.
   - Required: immediately stall=0, jb=0, flush_d=1, counters 0. After rst=1, the first cycle without a taken event gives jb=1.
